sprite_bounce_engine: RTL and testbench

//  Parametrised framebuffer writer for a bouncing rectangular sprite on the VGA-adapter pixel port.
//  FSM sequence: clear screen -> per frame tick (erase old sprite, move, draw new sprite).

---
 rtl/sprite_engine_pkg.sv | 18 +
 rtl/sprite_bounce_engine_rect_scanner.sv | 59 +++++
 rtl/sprite_bounce_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_sprite_bounce_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_engine_pkg.sv
// Shared types for the bouncing-sprite framebuffer writer: FSM states and
// direction encodings used by the position/direction registers.
package sprite_engine_pkg;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_WAIT  = 3'd1,
        S_ERASE = 3'd2,
        S_MOVE  = 3'd3,
        S_DRAW  = 3'd4
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/sprite_bounce_engine_rect_scanner.sv
// Rectangle raster generator, x fastest. While start is held high it emits
// one pixel coordinate per cycle; the counters rewind to zero on the last
// pixel, so the scanner is always ready for the next sweep without a load
// cycle. off_x/off_y are the absolute coordinates origin + offset.
module rect_scanner #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] origin_x,
    input  logic [YW-1:0] origin_y,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    output logic [XW-1:0] off_x,
    output logic [YW-1:0] off_y,
    output logic          valid,
    output logic          done
);

    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          last_x;
    logic          last_y;

    assign last_x = ({1'b0, cx_q} == (w - (XW+1)'(1)));
    assign last_y = ({1'b0, cy_q} == (h - (YW+1)'(1)));
    assign valid  = start;
    assign done   = start && last_x && last_y;
    assign off_x  = origin_x + cx_q;
    assign off_y  = origin_y + cy_q;

    // Next raster position: advance x, wrap to next row, rewind after the last pixel.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start) begin
            if (last_x) begin
                cx_d = '0;
                cy_d = last_y ? '0 : cy_q + YW'(1);
            end else begin
                cx_d = cx_q + XW'(1);
            end
        end
    end

    // Raster counter registers; reset returns to the first pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

endmodule

// File: rtl/sprite_bounce_engine.sv
// Bouncing-sprite framebuffer writer. Clears the screen, then on each frame
// tick erases the sprite, moves it one STEP per axis with wall bounces and
// redraws it. Emits at most one registered pixel write per cycle.
module sprite_bounce_engine
    import sprite_engine_pkg::*;
#(
    parameter int SCR_W     = 160,
    parameter int SCR_H     = 120,
    parameter int SPR_W     = 4,
    parameter int SPR_H     = 4,
    parameter int CLR_W     = 3,
    parameter int FRAME_DIV = 12500000,
    parameter int STEP      = 1,
    localparam int XW       = $clog2(SCR_W),
    localparam int YW       = $clog2(SCR_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_req,
    input  logic [CLR_W-1:0] sprite_colour,
    input  logic [CLR_W-1:0] bg_colour,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y,
    output logic [CLR_W-1:0] colour,
    output logic             plot,
    output logic [XW-1:0]    pos_x,
    output logic [YW-1:0]    pos_y,
    output logic             busy
);

    localparam int X_MAX = SCR_W - SPR_W;
    localparam int Y_MAX = SCR_H - SPR_H;
    localparam int TW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_DIV - 1);
    localparam logic [XW:0]   SCR_W_E   = (XW+1)'(SCR_W);
    localparam logic [YW:0]   SCR_H_E   = (YW+1)'(SCR_H);
    localparam logic [XW:0]   SPR_W_E   = (XW+1)'(SPR_W);
    localparam logic [YW:0]   SPR_H_E   = (YW+1)'(SPR_H);
    localparam logic [XW:0]   X_MAX_E   = (XW+1)'(X_MAX);
    localparam logic [YW:0]   Y_MAX_E   = (YW+1)'(Y_MAX);
    localparam logic [XW:0]   STEP_X    = (XW+1)'(STEP);
    localparam logic [YW:0]   STEP_Y    = (YW+1)'(STEP);

    state_e state_q, state_d;

    logic [TW-1:0]    tick_cnt_q;
    logic             tick;
    logic             tick_pend_q, tick_pend_d;
    logic             clr_pend_q, clr_pend_d;
    logic [XW-1:0]    pos_x_q, pos_x_d;
    logic [YW-1:0]    pos_y_q, pos_y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [CLR_W-1:0] colour_q;
    logic             plot_q;
    logic             busy_q;

    // FSM-driven controls
    logic             scan_run;
    logic [XW-1:0]    org_x;
    logic [YW-1:0]    org_y;
    logic [XW:0]      scan_w;
    logic [YW:0]      scan_h;
    logic [CLR_W-1:0] colour_sel;
    logic             move_en;
    logic             enter_clear;
    logic             tick_take;

    // Scanner outputs
    logic [XW-1:0]    scan_x;
    logic [YW-1:0]    scan_y;
    logic             scan_valid;
    logic             scan_done;

    // Wider position copies so +STEP can never wrap before the bound check
    logic [XW:0]      px_ext;
    logic [YW:0]      py_ext;

    rect_scanner #(
        .XW(XW),
        .YW(YW)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .start   (scan_run),
        .origin_x(org_x),
        .origin_y(org_y),
        .w       (scan_w),
        .h       (scan_h),
        .off_x   (scan_x),
        .off_y   (scan_y),
        .valid   (scan_valid),
        .done    (scan_done)
    );

    assign tick   = (tick_cnt_q == TICK_LAST);
    assign px_ext = {1'b0, pos_x_q};
    assign py_ext = {1'b0, pos_y_q};

    // Next-state and per-state scanner/colour selection.
    always_comb begin
        state_d     = state_q;
        scan_run    = 1'b0;
        org_x       = pos_x_q;
        org_y       = pos_y_q;
        scan_w      = SPR_W_E;
        scan_h      = SPR_H_E;
        colour_sel  = bg_colour;
        move_en     = 1'b0;
        enter_clear = 1'b0;
        tick_take   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                scan_run = 1'b1;
                org_x    = '0;
                org_y    = '0;
                scan_w   = SCR_W_E;
                scan_h   = SCR_H_E;
                if (scan_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (clr_pend_q) begin
                    state_d     = S_CLEAR;
                    enter_clear = 1'b1;
                end else if (tick_pend_q && enable) begin
                    state_d   = S_ERASE;
                    tick_take = 1'b1;
                end
            end
            S_ERASE: begin
                scan_run = 1'b1;
                if (scan_done) state_d = S_MOVE;
            end
            S_MOVE: begin
                move_en = 1'b1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                scan_run   = 1'b1;
                colour_sel = sprite_colour;
                if (scan_done) state_d = S_WAIT;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Pending flags: a new request always wins over the clear so nothing is lost.
    always_comb begin
        tick_pend_d = tick_pend_q;
        clr_pend_d  = clr_pend_q;
        if (tick_take)        tick_pend_d = 1'b0;
        if (tick && enable)   tick_pend_d = 1'b1;
        if (enter_clear)      clr_pend_d  = 1'b0;
        if (clear_req)        clr_pend_d  = 1'b1;
    end

    // Bounce arithmetic per axis, clamped at 0 and MAX.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (move_en) begin
            if (dir_x_q == DIR_RIGHT) begin
                if (px_ext + STEP_X >= X_MAX_E) begin
                    pos_x_d = XW'(X_MAX);
                    dir_x_d = DIR_LEFT;
                end else begin
                    pos_x_d = XW'(px_ext + STEP_X);
                end
            end else begin
                if (px_ext <= STEP_X) begin
                    pos_x_d = '0;
                    dir_x_d = DIR_RIGHT;
                end else begin
                    pos_x_d = XW'(px_ext - STEP_X);
                end
            end
            if (dir_y_q == DIR_DOWN) begin
                if (py_ext + STEP_Y >= Y_MAX_E) begin
                    pos_y_d = YW'(Y_MAX);
                    dir_y_d = DIR_UP;
                end else begin
                    pos_y_d = YW'(py_ext + STEP_Y);
                end
            end else begin
                if (py_ext <= STEP_Y) begin
                    pos_y_d = '0;
                    dir_y_d = DIR_DOWN;
                end else begin
                    pos_y_d = YW'(py_ext - STEP_Y);
                end
            end
        end
    end

    // State, divider, flags, sprite position and registered pixel outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            tick_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            pos_x_q     <= XW'(X_MAX);
            pos_y_q     <= '0;
            dir_x_q     <= DIR_LEFT;
            dir_y_q     <= DIR_DOWN;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + TW'(1);
            tick_pend_q <= tick_pend_d;
            clr_pend_q  <= clr_pend_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            x_q         <= scan_x;
            y_q         <= scan_y;
            colour_q    <= colour_sel;
            plot_q      <= scan_valid;
            // Lags the state by one cycle, matching the pixel pipeline.
            busy_q      <= (state_q != S_WAIT);
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign pos_x  = pos_x_q;
    assign pos_y  = pos_y_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sprite_bounce_engine.sv
// Directed bench for sprite_bounce_engine on a 16x12 screen with a 4x4 sprite.
module tb_sprite_bounce_engine;

    localparam int SCR_W = 16;
    localparam int SCR_H = 12;
    localparam int BG    = 1;
    localparam int SPR   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       clear_req = 1'b0;
    logic [2:0] sprite_colour = 3'(SPR);
    logic [2:0] bg_colour = 3'(BG);
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;
    pix_t pq[$];

    int exp_x[2:13] = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int exp_y[2:13] = '{ 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3};

    sprite_bounce_engine #(
        .SCR_W    (SCR_W),
        .SCR_H    (SCR_H),
        .SPR_W    (4),
        .SPR_H    (4),
        .CLR_W    (3),
        .FRAME_DIV(64),
        .STEP     (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear_req    (clear_req),
        .sprite_colour(sprite_colour),
        .bg_colour    (bg_colour),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .plot         (plot),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Capture every pixel write, sampled on the falling edge.
    always @(negedge clk) begin
        if (plot === 1'b1) pq.push_back('{int'(x), int'(y), int'(colour)});
    end

    task automatic chk(input string tag, input int got, input int expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, expv);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Counts pixels in pq[base..] that do not match a w x h raster at (x0,y0).
    function automatic int rect_bad(input int base, input int x0, input int y0,
                                    input int w, input int h, input int c);
        int bad = 0;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                int idx = base + yy * w + xx;
                if (idx >= pq.size()) bad++;
                else if (pq[idx].px != x0 + xx || pq[idx].py != y0 + yy || pq[idx].pc != c) bad++;
            end
        end
        return bad;
    endfunction

    task automatic wait_busy(input logic val, input int limit, input string tag);
        int n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(busy), int'(val));
    endtask

    task automatic run_tick();
        enable = 1'b1;
        wait_busy(1'b1, 100, "tick_start");
        enable = 1'b0;
        wait_busy(1'b0, 60, "tick_end");
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_pos_x", int'(pos_x), 12);
        chk("rst_pos_y", int'(pos_y), 0);

        // Power-on clear: 192 bg pixels in raster order
        pq.delete();
        reset = 1'b0;
        wait_busy(1'b1, 10, "clr_busy_rise");
        wait_busy(1'b0, 400, "clr_busy_fall");
        chk("clr_count", pq.size(), 192);
        chk("clr_raster_bad", rect_bad(0, 0, 0, SCR_W, SCR_H, BG), 0);
        chk("clr_pos_x", int'(pos_x), 12);
        chk("clr_pos_y", int'(pos_y), 0);

        // First tick: erase at (12,0), draw at (11,1)
        pq.delete();
        run_tick();
        chk("t1_count", pq.size(), 32);
        chk("t1_erase_bad", rect_bad(0, 12, 0, 4, 4, BG), 0);
        chk("t1_draw_bad", rect_bad(16, 11, 1, 4, 4, SPR), 0);
        chk("t1_pos_x", int'(pos_x), 11);
        chk("t1_pos_y", int'(pos_y), 1);

        // Ticks 2..13: left wall bounce on x, bottom bounce at 8 on y
        for (int t = 2; t <= 13; t++) begin
            run_tick();
            chk($sformatf("t%0d_pos_x", t), int'(pos_x), exp_x[t]);
            chk($sformatf("t%0d_pos_y", t), int'(pos_y), exp_y[t]);
        end

        // Tick 14 with clear_req during draw: draw finishes, then full clear
        pq.delete();
        enable = 1'b1;
        wait_busy(1'b1, 100, "cd_start");
        enable = 1'b0;
        repeat (20) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (400) @(negedge clk);
        chk("cd_count", pq.size(), 224);
        chk("cd_erase_bad", rect_bad(0, 1, 3, 4, 4, BG), 0);
        chk("cd_draw_bad", rect_bad(16, 2, 2, 4, 4, SPR), 0);
        chk("cd_clear_bad", rect_bad(32, 0, 0, SCR_W, SCR_H, BG), 0);
        chk("cd_pos_x", int'(pos_x), 2);
        chk("cd_pos_y", int'(pos_y), 2);
        chk("cd_busy", int'(busy), 0);

        // Freeze: enable low for 5 tick periods
        pq.delete();
        repeat (320) @(negedge clk);
        chk("frz_plots", pq.size(), 0);
        chk("frz_pos_x", int'(pos_x), 2);
        chk("frz_pos_y", int'(pos_y), 2);
        run_tick();
        chk("res_pos_x", int'(pos_x), 3);
        chk("res_pos_y", int'(pos_y), 1);

        // Reset in the middle of an erase
        enable = 1'b1;
        wait_busy(1'b1, 100, "me_start");
        enable = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("me_plot", int'(plot), 0);
        chk("me_busy", int'(busy), 0);
        chk("me_pos_x", int'(pos_x), 12);
        chk("me_pos_y", int'(pos_y), 0);
        pq.delete();
        reset = 1'b0;
        repeat (400) @(negedge clk);
        chk("me_clr_count", pq.size(), 192);
        chk("me_clr_bad", rect_bad(0, 0, 0, SCR_W, SCR_H, BG), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
